// File: rtl/ucsbece154_icache_refill.sv
// ucsbece154_icache_refill
//
// Instruction-cache line refill engine. On a miss it issues one burst read
// for the block containing the missing instruction, collects BLOCK_WORDS
// words from memory (tolerating gaps between them) and presents the
// finished line for one cycle.
//
// Optional feature macro: UCSBECE154_REFILL_FORWARD_EN
//   When defined, the word at the missing instruction's offset is forwarded
//   combinationally on EarlyValid/EarlyWord as it arrives.
//   When undefined, EarlyValid and EarlyWord are tied to 0.
//
// Parameters:
//   BLOCK_WORDS  words per cache line and per memory burst (power of two, 2..16)
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high reset
//   MissReq      line fill request from the cache (sampled only in IDLE)
//   MissAddress  byte address of the missing instruction
//   Busy         high whenever the engine is not IDLE
//   ReadRequest  one-cycle burst request to instruction memory
//   ReadAddress  block-aligned burst start address (stable through the burst)
//   DataIn       burst word from memory
//   DataReady    DataIn is valid this cycle
//   LineValid    one-cycle pulse, completed line available
//   LineAddress  block-aligned address of the completed line
//   LineData     completed line, word i at bits [32*i+31:32*i]
//   EarlyValid   critical word is on EarlyWord this cycle
//   EarlyWord    critical word forward
//   DebugState   current FSM state (0 IDLE, 1 REQ, 2 RECV, 3 DONE)
//
// Handshake: ReadRequest is a single-cycle command with no ready; memory
// answers with BLOCK_WORDS cycles of DataReady=1, in order, with any number
// of idle cycles between them. Each DataReady=1 cycle in RECV transfers
// exactly one word; DataReady outside RECV is ignored.

module ucsbece154_icache_refill #(
    parameter int BLOCK_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MissReq,
    input  logic [31:0]                MissAddress,
    output logic                       Busy,
    output logic                       ReadRequest,
    output logic [31:0]                ReadAddress,
    input  logic [31:0]                DataIn,
    input  logic                       DataReady,
    output logic                       LineValid,
    output logic [31:0]                LineAddress,
    output logic [32*BLOCK_WORDS-1:0]  LineData,
    output logic                       EarlyValid,
    output logic [31:0]                EarlyWord,
    output logic [1:0]                 DebugState
);

    localparam int                OFF_W      = $clog2(BLOCK_WORDS);
    localparam logic [31:0]       BLOCK_MASK = 32'(BLOCK_WORDS * 4 - 1);
    localparam logic [OFF_W-1:0]  LAST_WORD  = OFF_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                      r_state;
    logic [OFF_W-1:0]            r_cnt;
    logic [31:0]                 r_addr;
    logic [31:0]                 r_line_addr;
    logic [32*BLOCK_WORDS-1:0]   r_line;

    logic [31:0]                 w_block_addr;

    assign w_block_addr = MissAddress & ~BLOCK_MASK;

`ifdef UCSBECE154_REFILL_FORWARD_EN
    logic [OFF_W-1:0]            r_crit;
    logic [OFF_W-1:0]            w_offset;

    assign w_offset = MissAddress[OFF_W+1:2];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_line_addr <= '0;
            r_line      <= '0;
`ifdef UCSBECE154_REFILL_FORWARD_EN
            r_crit      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MissReq) begin
                        r_addr  <= w_block_addr;
`ifdef UCSBECE154_REFILL_FORWARD_EN
                        r_crit  <= w_offset;
`endif
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_cnt   <= '0;
                    r_state <= S_RECV;
                end
                S_RECV: begin
                    if (DataReady) begin
                        // {r_cnt, 5'd0} is the bit offset of word r_cnt.
                        r_line[{r_cnt, 5'd0} +: 32] <= DataIn;
                        r_cnt <= r_cnt + OFF_W'(1);
                        if (r_cnt == LAST_WORD) begin
                            // Line address only moves when a line completes,
                            // so it stays paired with the data it describes.
                            r_line_addr <= r_addr;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy        = (r_state != S_IDLE);
    assign ReadRequest = (r_state == S_REQ);
    assign ReadAddress = r_addr;
    assign LineValid   = (r_state == S_DONE);
    assign LineAddress = r_line_addr;
    assign LineData    = r_line;
    assign DebugState  = r_state;

`ifdef UCSBECE154_REFILL_FORWARD_EN
    assign EarlyValid = (r_state == S_RECV) && DataReady && (r_cnt == r_crit);
    assign EarlyWord  = DataIn;
`else
    assign EarlyValid = 1'b0;
    assign EarlyWord  = 32'd0;
`endif

endmodule
